// File: rtl/stereo_pixel_aligner.sv
// Pairs two independently timed camera pixel streams through per-camera FIFOs and emits
// left/right pixels together with a shared raster coordinate, realigning on dual SOF.
module stereo_pixel_aligner #(
  parameter int HRES       = 640,
  parameter int VRES       = 360,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cam1_valid_in,
  input  logic [7:0]  cam1_pixel_in,
  input  logic        cam1_sof_in,
  input  logic        cam2_valid_in,
  input  logic [7:0]  cam2_pixel_in,
  input  logic        cam2_sof_in,
  output logic        data_cam1_valid,
  output logic        data_cam2_valid,
  output logic [7:0]  cam1_pixel_out,
  output logic [7:0]  cam2_pixel_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        locked_out,
  output logic        overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [10:0] H_LAST  = 11'(HRES - 1);
  localparam logic [9:0]  V_LAST  = 10'(VRES - 1);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ALIGNED,
    FLUSH
  } state_t;

  state_t state, state_next;

  // Entry layout: {sof, pixel[7:0]}; index 0 = cam1, index 1 = cam2.
  logic [8:0]  mem [2][FIFO_DEPTH];
  logic [AW:0] wr_ptr [2];
  logic [AW:0] rd_ptr [2];
  logic [8:0]  cam_entry [2];
  logic [8:0]  head [2];
  logic [1:0]  cam_valid;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  head_sof;
  logic [1:0]  pop;
  logic [1:0]  wr_en;
  logic [1:0]  ovf;
  logic        emit;
  logic        last_pos;
  logic        pair_valid;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;

  assign cam_valid    = {cam2_valid_in, cam1_valid_in};
  assign cam_entry[0] = {cam1_sof_in, cam1_pixel_in};
  assign cam_entry[1] = {cam2_sof_in, cam2_pixel_in};
  assign last_pos     = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      empty[c]    = (wr_ptr[c] == rd_ptr[c]);
      full[c]     = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                    (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
      head[c]     = mem[c][rd_ptr[c][AW-1:0]];
      head_sof[c] = head[c][8];
    end
  end

  always_comb begin
    state_next = state;
    pop        = '0;
    emit       = 1'b0;
    case (state)
      WAIT_SOF: begin
        for (int unsigned c = 0; c < 2; c++) begin
          if (!empty[c] && !head_sof[c]) pop[c] = 1'b1;
        end
        if (!empty[0] && !empty[1] && head_sof[0] && head_sof[1]) state_next = ALIGNED;
      end
      ALIGNED: begin
        // The frame's first pair always carries sof on both sides, so any mixed pair is a slip.
        if (!empty[0] && !empty[1]) begin
          if (head_sof[0] != head_sof[1]) begin
            state_next = WAIT_SOF;
          end else begin
            pop  = '1;
            emit = 1'b1;
            if (last_pos) state_next = WAIT_SOF;
          end
        end
      end
      FLUSH: state_next = WAIT_SOF;
      default: state_next = WAIT_SOF;
    endcase

    // A full FIFO still accepts a write when its head is popped on the same edge.
    for (int unsigned c = 0; c < 2; c++) begin
      ovf[c]   = (state != FLUSH) && cam_valid[c] && full[c] && !pop[c];
      wr_en[c] = (state != FLUSH) && cam_valid[c] && !ovf[c];
    end
    if (|ovf) state_next = FLUSH;
  end

  always_ff @(posedge clk_in) begin
    for (int unsigned c = 0; c < 2; c++) begin
      if (wr_en[c]) mem[c][wr_ptr[c][AW-1:0]] <= cam_entry[c];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else if (state == FLUSH) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (pop[c])   rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= WAIT_SOF;
    else         state <= state_next;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pair_valid     <= 1'b0;
      cam1_pixel_out <= '0;
      cam2_pixel_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      h_cnt          <= '0;
      v_cnt          <= '0;
      locked_out     <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      pair_valid   <= emit;
      locked_out   <= (state_next == ALIGNED);
      overflow_out <= overflow_out | (|ovf);
      if (emit) begin
        cam1_pixel_out <= head[0][7:0];
        cam2_pixel_out <= head[1][7:0];
        hcount_out     <= h_cnt;
        vcount_out     <= v_cnt;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end else if (state != ALIGNED) begin
        // Coordinates stay parked at the origin until the next alignment.
        h_cnt <= '0;
        v_cnt <= '0;
      end
    end
  end

  assign data_cam1_valid = pair_valid;
  assign data_cam2_valid = pair_valid;

endmodule
